// File: rtl/pc_pkg.sv
// Shared types for the program counter / return-stack block.
package pc_pkg;

  typedef enum logic [1:0] {
    PC_NEXT = 2'd0,
    PC_JUMP = 2'd1,
    PC_CALL = 2'd2,
    PC_RET  = 2'd3
  } pc_op_t;

  typedef enum logic [2:0] {
    J_ALWAYS = 3'd0,
    J_Z      = 3'd1,
    J_NZ     = 3'd2,
    J_LT     = 3'd3,
    J_GE     = 3'd4,
    J_LE     = 3'd5,
    J_C      = 3'd6,
    J_NC     = 3'd7
  } jcond_t;

  typedef enum logic [1:0] {
    F_NONE      = 2'd0,
    F_OVERFLOW  = 2'd1,
    F_UNDERFLOW = 2'd2
  } fault_t;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } pc_state_t;

  // Jump condition evaluation from the ALU flags (lt = s^o is signed less-than).
  function automatic logic cond_taken(input jcond_t c, input logic z, input logic s,
                                      input logic o, input logic cy);
    logic lt;
    lt = s ^ o;
    case (c)
      J_ALWAYS: cond_taken = 1'b1;
      J_Z:      cond_taken = z;
      J_NZ:     cond_taken = !z;
      J_LT:     cond_taken = lt;
      J_GE:     cond_taken = !lt;
      J_LE:     cond_taken = z | lt;
      J_C:      cond_taken = cy;
      J_NC:     cond_taken = !cy;
      default:  cond_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pc_stack_ret_stack.sv
// Register-array LIFO holding return addresses. push and pop are exclusive.
module ret_stack
  import pc_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [A_WIDTH-1:0]           din,
  output logic [A_WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [A_WIDTH-1:0] mem [DEPTH];
  logic [CW-1:0]      cnt_m1;

  assign cnt_m1 = count - CW'(1);
  assign top    = mem[cnt_m1[IW-1:0]];
  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);

  // Occupancy counter; guarded so a stray push/pop never wraps it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                count <= '0;
    else if (push && !full) count <= count + CW'(1);
    else if (pop && !empty) count <= cnt_m1;
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (push && !full) mem[count[IW-1:0]] <= din;
  end

endmodule

// File: rtl/pc_stack.sv
// Fetch-stage program counter with conditional jumps, CALL/RET return stack,
// stall and a sticky fault state left only by reset.
module pc_stack
  import pc_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        stall,
  input  pc_op_t                      op,
  input  jcond_t                      cond,
  input  logic                        rel,
  input  logic [A_WIDTH-1:0]          target,
  input  logic                        flag_z,
  input  logic                        flag_s,
  input  logic                        flag_o,
  input  logic                        flag_c,
  output logic [A_WIDTH-1:0]          addr,
  output logic [$clog2(DEPTH+1)-1:0]  sp,
  output logic                        fault,
  output fault_t                      fault_code
);

  pc_state_t          state, state_n;
  fault_t             code_n;
  logic [A_WIDTH-1:0] addr_n, inc, tgt, top;
  logic               push, pop, full, empty;

  // Same-width add is exactly the sign-extended offset modulo 2^A_WIDTH.
  assign inc   = addr + A_WIDTH'(1);
  assign tgt   = rel ? (addr + target) : target;
  assign fault = (state == FAULT);

  ret_stack #(.A_WIDTH(A_WIDTH), .DEPTH(DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .top   (top),
    .count (sp),
    .full  (full),
    .empty (empty)
  );

  // State, PC and fault code registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= RUN;
      addr       <= '0;
      fault_code <= F_NONE;
    end else begin
      state      <= state_n;
      addr       <= addr_n;
      fault_code <= code_n;
    end
  end

  // Next-state / next-PC decode; stall and FAULT both hold everything.
  always_comb begin
    state_n = state;
    addr_n  = addr;
    code_n  = fault_code;
    push    = 1'b0;
    pop     = 1'b0;
    if (state == RUN && !stall) begin
      case (op)
        PC_NEXT: addr_n = inc;
        PC_JUMP: addr_n = cond_taken(cond, flag_z, flag_s, flag_o, flag_c) ? tgt : inc;
        PC_CALL: begin
          if (full) begin
            state_n = FAULT;
            code_n  = F_OVERFLOW;
          end else begin
            push   = 1'b1;
            addr_n = tgt;
          end
        end
        PC_RET: begin
          if (empty) begin
            state_n = FAULT;
            code_n  = F_UNDERFLOW;
          end else begin
            pop    = 1'b1;
            addr_n = top;
          end
        end
        default: addr_n = addr;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_stack.sv
// Randomized + directed bench for pc_stack against a queue-based reference model.
module tb_pc_stack;
  import pc_pkg::*;

  localparam int AW  = 8;
  localparam int DP  = 4;
  localparam int MOD = 1 << AW;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic                      stall = 1'b0;
  pc_op_t                    op = PC_NEXT;
  jcond_t                    cond = J_ALWAYS;
  logic                      rel = 1'b0;
  logic [AW-1:0]             target = '0;
  logic                      flag_z = 1'b0, flag_s = 1'b0, flag_o = 1'b0, flag_c = 1'b0;
  logic [AW-1:0]             addr;
  logic [$clog2(DP+1)-1:0]   sp;
  logic                      fault;
  fault_t                    fault_code;

  pc_stack #(.A_WIDTH(AW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .op(op), .cond(cond), .rel(rel),
    .target(target), .flag_z(flag_z), .flag_s(flag_s), .flag_o(flag_o),
    .flag_c(flag_c), .addr(addr), .sp(sp), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;

  // Reference model state
  int m_addr;
  int m_stk[$];
  bit m_fault;
  int m_code;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".addr"},  32'(addr), 32'(m_addr));
    chk({tag, ".sp"},    32'(sp), 32'(m_stk.size()));
    chk({tag, ".fault"}, 32'(fault), 32'(m_fault));
    chk({tag, ".code"},  32'(fault_code), 32'(m_code));
  endtask

  function automatic bit taken_ref(int c, bit z, bit s, bit o, bit cy);
    bit lt = (s != o);
    case (c)
      0: return 1;
      1: return z;
      2: return !z;
      3: return lt;
      4: return !lt;
      5: return z || lt;
      6: return cy;
      default: return !cy;
    endcase
  endfunction

  function automatic int wrap(int v);
    return ((v % MOD) + MOD) % MOD;
  endfunction

  task automatic set(input pc_op_t o_, input jcond_t c_, input bit r_, input int t_,
                     input bit z_, input bit s_, input bit ov_, input bit cy_, input bit st_);
    op = o_; cond = c_; rel = r_; target = AW'(t_);
    flag_z = z_; flag_s = s_; flag_o = ov_; flag_c = cy_; stall = st_;
  endtask

  // Advance one clock: model next state from the current inputs, then compare.
  task automatic tick(input string tag);
    int t, off;
    t   = int'(target);
    off = (t >= MOD/2) ? t - MOD : t;
    t   = rel ? wrap(m_addr + off) : t;
    if (!m_fault && !stall) begin
      case (op)
        PC_NEXT: m_addr = wrap(m_addr + 1);
        PC_JUMP: m_addr = taken_ref(int'(cond), flag_z, flag_s, flag_o, flag_c) ? t : wrap(m_addr + 1);
        PC_CALL: if (m_stk.size() == DP) begin m_fault = 1; m_code = 1; end
                 else begin m_stk.push_back(wrap(m_addr + 1)); m_addr = t; end
        default: if (m_stk.size() == 0) begin m_fault = 1; m_code = 2; end
                 else m_addr = m_stk.pop_back();
      endcase
    end
    @(posedge clk); #1;
    chk_all(tag);
  endtask

  task automatic model_reset();
    m_addr = 0; m_stk.delete(); m_fault = 0; m_code = 0;
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1; #1;
    model_reset();
    chk_all(tag);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic jmp_abs(input int a);
    set(PC_JUMP, J_ALWAYS, 0, a, 0, 0, 0, 0, 0); tick("jmp_setup");
  endtask

  initial begin
    model_reset();
    #2;
    chk_all("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential increment and wrap
    set(PC_NEXT, J_ALWAYS, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick("next");
    jmp_abs(255);
    set(PC_NEXT, J_ALWAYS, 0, 0, 0, 0, 0, 0, 0); tick("wrap255");

    // Conditional jumps
    jmp_abs(10);
    set(PC_JUMP, J_LT, 0, 40, 0, 1, 1, 0, 0); tick("jlt_not");
    jmp_abs(10);
    set(PC_JUMP, J_LT, 0, 40, 0, 1, 0, 0, 0); tick("jlt_taken");
    set(PC_JUMP, J_LE, 0, 77, 1, 0, 0, 0, 0); tick("jle_z");

    // Relative jumps
    jmp_abs(20);
    set(PC_JUMP, J_ALWAYS, 1, 8'hFB, 0, 0, 0, 0, 0); tick("rel_neg");
    jmp_abs(250);
    set(PC_JUMP, J_ALWAYS, 1, 10, 0, 0, 0, 0, 0); tick("rel_wrap");

    // Nested call/return
    jmp_abs(5);
    set(PC_CALL, J_ALWAYS, 0, 100, 0, 0, 0, 0, 0); tick("call1");
    set(PC_CALL, J_ALWAYS, 0, 200, 0, 0, 0, 0, 0); tick("call2");
    set(PC_RET,  J_ALWAYS, 0, 0, 0, 0, 0, 0, 0);   tick("ret1");
    tick("ret2");

    // Overflow, frozen fault, reset clear
    for (int i = 0; i < DP; i++) begin
      set(PC_CALL, J_ALWAYS, 0, 30 + i * 10, 0, 0, 0, 0, 0); tick("fill");
    end
    set(PC_CALL, J_ALWAYS, 0, 99, 0, 0, 0, 0, 0); tick("overflow");
    set(PC_NEXT, J_ALWAYS, 0, 0, 0, 0, 0, 0, 0);  tick("frozen_next");
    set(PC_RET,  J_ALWAYS, 0, 0, 0, 0, 0, 0, 0);  tick("frozen_ret");
    do_reset("ovf_rst");

    // Underflow from reset
    set(PC_RET, J_ALWAYS, 0, 0, 0, 0, 0, 0, 0); tick("underflow");
    tick("underflow_hold");
    do_reset("udf_rst");

    // Stall priority, then release
    jmp_abs(7);
    set(PC_CALL, J_ALWAYS, 0, 100, 0, 0, 0, 0, 1); tick("stall_call");
    stall = 1'b0; tick("call_after_stall");
    set(PC_NEXT, J_ALWAYS, 0, 0, 0, 0, 0, 0, 0); tick("next_after_call");
    do_reset("mid_rst");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset("rnd_rst");
      end else begin
        set(pc_op_t'($urandom_range(0, 3)), jcond_t'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, MOD - 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 7) == 0));
        tick("rnd");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_stack.md
# pc_stack

Parametrised program counter with conditional absolute/relative jumps, an internal return-address stack for CALL/RET, a stall input and a sticky fault state. Sits in the fetch stage: the decoder drives the operation, the condition, the target and the ALU flags, and `addr` drives the instruction memory address. It replaces the fixed-width, stack-less PC in designs that need subroutines.

## Interface
- `A_WIDTH`, default 8: PC and target width in bits.
- `DEPTH`, default 4: number of return-stack entries; must be ≥ 2.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `stall`  in  1  hold all state this cycle.
- `op`  in  `pc_op_t` (2)  `PC_NEXT`, `PC_JUMP`, `PC_CALL`, `PC_RET`.
- `cond`  in  `jcond_t` (3)  jump condition; used by `PC_JUMP` only.
- `rel`  in  1  target = `addr` + signed `target`; otherwise target is absolute.
- `target`  in  `A_WIDTH`  jump/call address or two's-complement offset.
- `flag_z`, `flag_s`, `flag_o`, `flag_c`  in  1 each  ALU flags, sampled in the same cycle.
- `addr`  out  `A_WIDTH`  current PC.
- `sp`  out  `$clog2(DEPTH+1)`  number of valid stack entries.
- `fault`  out  1  sticky; PC frozen.
- `fault_code`  out  `fault_t` (2)  `F_NONE`, `F_OVERFLOW`, `F_UNDERFLOW`.

## Operation
- States: `RUN`, `FAULT`. After reset the block is in `RUN`.
- `FAULT` is left only by reset. While in `FAULT`, `addr`, `sp` and the stack are frozen and all inputs are ignored.
- In `RUN` with `stall`=1, nothing changes. `stall` has priority over `op`.
- `inc` = `addr`+1 mod 2^`A_WIDTH`. Wrap from all-ones to 0 is legal and raises no fault.
- `tgt` = `rel` ? (`addr` + sign-extended `target`) mod 2^`A_WIDTH` : `target`.
- `PC_NEXT`: `addr` ← `inc`.
- `PC_JUMP`: `addr` ← `taken` ? `tgt` : `inc`. Conditions and when they are taken:
  - `J_ALWAYS`: always.
  - `J_Z`: `z`.
  - `J_NZ`: !`z`.
  - `J_LT`: `s`^`o` (signed less-than).
  - `J_GE`: !(`s`^`o`).
  - `J_LE`: `z` | (`s`^`o`).
  - `J_C`: `c`.
  - `J_NC`: !`c`.
- `PC_CALL`: unconditional. If `sp`<`DEPTH`: push `inc`, `sp`++, `addr` ← `tgt`. If `sp`==`DEPTH`: no push, `addr` held, `fault_code` ← `F_OVERFLOW`, enter `FAULT`.
- `PC_RET`: if `sp`>0: `addr` ← top entry, `sp`--. If `sp`==0: `addr` held, `fault_code` ← `F_UNDERFLOW`, enter `FAULT`.
- `cond` and `rel` are ignored for `PC_RET`. `cond` is ignored for `PC_CALL`.

## Timing
- Reset values: `addr`=0, `sp`=0, `fault`=0, `fault_code`=`F_NONE`. Stack contents are don't-care.
- Reset asserted mid-operation returns all outputs to these values immediately (asynchronously).
- Flags, `op`, `cond`, `rel` and `target` are combinational inputs sampled at the rising edge. The new `addr` is visible one cycle after the `op` is applied.
- `fault` goes high in the cycle after the offending edge and stays high until reset.
- A CALL immediately followed by a RET returns to the call address + 1; back-to-back operations need no bubble.
- A push at `sp`==`DEPTH`-1 is legal and fills the stack. The next CALL faults.

## Structure
- Shared package `pc_pkg` holds `pc_op_t`, `jcond_t` and `fault_t` with the encodings listed above.
- Sub-module `ret_stack #(A_WIDTH, DEPTH)`:
  - Register-array LIFO with `push`, `pop`, `din`, `top`, `count`, `full`, `empty`, plus the same `clk`/`rst`.
  - Pop and push are never asserted together.
- `pc_stack` holds the FSM, the condition evaluation and the target adder.

## Test plan
- Reset, then 3× `PC_NEXT` → `addr` 0,1,2,3. With `addr`=255 (`A_WIDTH`=8), `PC_NEXT` → 0, `fault`=0.
- `addr`=10, `PC_JUMP` `J_LT` with `s`=1, `o`=1 → 11 (not taken). Same with `s`=1, `o`=0 → `target`=40. `J_LE` with `z`=1 → taken.
- `addr`=20, `rel`=1, `target`=8'hFB, `J_ALWAYS` → 15. `addr`=250, `rel`=1, `target`=10 → 4.
- `addr`=5, `CALL` 100, `CALL` 200, `RET`, `RET` → `addr` 100, 200, 101, 6; `sp` 1, 2, 1, 0.
- `DEPTH`=4: 4 CALLs then a 5th CALL → `addr` held, `fault`=1, `F_OVERFLOW`; further ops ignored; `rst` clears to 0/`F_NONE`. From reset, `RET` → `F_UNDERFLOW`, `addr`=0.
- `stall`=1 during `CALL` 100 → `addr` and `sp` unchanged. Release `stall` → call executes next edge. Assert `rst` mid-sequence → all outputs at reset values before the next edge.
